// File: rtl/sdram_sched.sv
// sdram_sched: captures packets from NUM_CH sensor channels plus a downlink
// read request, arbitrates between them, and sequences each packet as 16-bit
// word writes (or a single read) through the SDRAM command handshake.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | no transfer in flight; arbitrate pending sources
// ISSUE      | one cycle; command, address and data registered to outputs
// WAIT_ACK   | waiting for SDRAM_STATUS to rise; re-issue on timeout
// WAIT_DONE  | interface busy; on fall advance word or finish the packet
module sdram_sched #(
    parameter int NUM_CH        = 2,
    parameter int MAX_WORDS     = 5,
    parameter int READ_PRIORITY = 1,
    parameter int ACK_TIMEOUT   = 15
) (
    input  logic                            CLK_48MHZ,
    input  logic                            RESET_N,
    input  logic [NUM_CH-1:0]               CH_VALID,
    input  logic [NUM_CH*MAX_WORDS*16-1:0]  CH_DATA,
    input  logic [NUM_CH*4-1:0]             CH_LEN,
    input  logic                            READ_CMD,
    input  logic                            SDRAM_STATUS,
    input  logic [1:0]                      BA_WRITE,
    input  logic [12:0]                     ROW_WRITE,
    input  logic [8:0]                      COL_WRITE,
    input  logic [1:0]                      BA_READ,
    input  logic [12:0]                     ROW_READ,
    input  logic [8:0]                      COL_READ,
    output logic [1:0]                      CMD_OUT,
    output logic [15:0]                     DATA_OUT,
    output logic [1:0]                      BA_OUT,
    output logic [12:0]                     ROW_OUT,
    output logic [8:0]                      COL_OUT,
    output logic                            NEXT_WRITE,
    output logic                            NEXT_READ,
    output logic [NUM_CH:0]                 DROP,
    output logic                            TIMEOUT_ERR
);

    localparam int NSLOT = NUM_CH + 1;
    localparam int SW    = $clog2(NSLOT);
    localparam int TW    = $clog2(ACK_TIMEOUT + 1);
    localparam int PW    = MAX_WORDS * 16;
    localparam logic [SW-1:0] RD_SLOT   = SW'(NUM_CH);
    localparam logic [3:0]    MAX_LEN   = 4'(MAX_WORDS);
    localparam logic [TW-1:0] TO_LOAD   = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_ACK  = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     slot_q, slot_d;
    logic [3:0]        idx_q, idx_d;
    logic [TW-1:0]     to_cnt_q, to_cnt_d;
    logic [SW-1:0]     rr_ptr_q, rr_ptr_d;

    logic [PW-1:0]     pkt_buf [NUM_CH];
    logic [3:0]        len_q   [NUM_CH];
    logic [NUM_CH-1:0] pending_q;
    logic              rd_pending_q;
    logic              rd_sync_q;
    logic              rd_prev_q;
    logic              rd_rise;

    logic [NUM_CH-1:0] ch_accept;
    logic [NUM_CH:0]   drop_set;
    logic [NUM_CH-1:0] clr_ch;
    logic              clr_rd;
    logic              issue;
    logic              next_w_d;
    logic              next_r_d;
    logic              to_fire;

    logic              grant_vld;
    logic [SW-1:0]     grant_slot;
    logic [NSLOT-1:0]  req;
    logic              cur_is_read;
    logic [3:0]        cur_len;
    logic [15:0]       cur_word;

    assign rd_rise     = rd_sync_q & ~rd_prev_q;
    assign req         = {rd_pending_q, pending_q};
    assign cur_is_read = (slot_q == RD_SLOT);

    // Decide per source whether an arriving request is accepted or dropped.
    always_comb begin
        ch_accept = '0;
        drop_set  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (CH_VALID[c]) begin
                if (pending_q[c] || (CH_LEN[4*c +: 4] == 4'd0)) begin
                    drop_set[c] = 1'b1;
                end else begin
                    ch_accept[c] = 1'b1;
                end
            end
        end
        if (rd_rise && rd_pending_q) begin
            drop_set[NUM_CH] = 1'b1;
        end
    end

    // Capture packet buffers, pending flags, read edge detect and drop flags.
    always_ff @(posedge CLK_48MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            pending_q    <= '0;
            rd_pending_q <= 1'b0;
            rd_sync_q    <= 1'b0;
            rd_prev_q    <= 1'b0;
            DROP         <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                pkt_buf[c] <= '0;
                len_q[c]   <= '0;
            end
        end else begin
            rd_sync_q    <= READ_CMD;
            rd_prev_q    <= rd_sync_q;
            pending_q    <= (pending_q & ~clr_ch) | ch_accept;
            rd_pending_q <= (rd_pending_q & ~clr_rd) | (rd_rise & ~rd_pending_q);
            DROP         <= DROP | drop_set;
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_accept[c]) begin
                    pkt_buf[c] <= CH_DATA[c*PW +: PW];
                    len_q[c]   <= (CH_LEN[4*c +: 4] > MAX_LEN) ? MAX_LEN : CH_LEN[4*c +: 4];
                end
            end
        end
    end

    // Pick the next source: read first when prioritised, else round-robin from rr_ptr.
    always_comb begin
        int s;
        s          = 0;
        grant_vld  = 1'b0;
        grant_slot = '0;
        if ((READ_PRIORITY != 0) && rd_pending_q) begin
            grant_vld  = 1'b1;
            grant_slot = RD_SLOT;
        end else begin
            for (int k = 0; k < NSLOT; k++) begin
                s = int'(rr_ptr_q) + k;
                if (s >= NSLOT) begin
                    s = s - NSLOT;
                end
                if (!grant_vld && req[s]) begin
                    grant_vld  = 1'b1;
                    grant_slot = SW'(s);
                end
            end
        end
    end

    // Select length and current word of the channel being served.
    always_comb begin
        cur_len  = '0;
        cur_word = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (slot_q == SW'(c)) begin
                cur_len = len_q[c];
                for (int w = 0; w < MAX_WORDS; w++) begin
                    if (idx_q == 4'(w)) begin
                        cur_word = pkt_buf[c][16*w +: 16];
                    end
                end
            end
        end
    end

    // Sequencer state register.
    always_ff @(posedge CLK_48MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= S_IDLE;
            slot_q   <= '0;
            idx_q    <= '0;
            to_cnt_q <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            idx_q    <= idx_d;
            to_cnt_q <= to_cnt_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Sequencer next state; timeout is a down-counter loaded when leaving ISSUE.
    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        idx_d    = idx_q;
        to_cnt_d = to_cnt_q;
        rr_ptr_d = rr_ptr_q;
        clr_ch   = '0;
        clr_rd   = 1'b0;
        issue    = 1'b0;
        next_w_d = 1'b0;
        next_r_d = 1'b0;
        to_fire  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_vld && !SDRAM_STATUS) begin
                    state_d  = S_ISSUE;
                    slot_d   = grant_slot;
                    idx_d    = '0;
                    rr_ptr_d = (grant_slot == RD_SLOT) ? '0 : grant_slot + 1'b1;
                end
            end
            S_ISSUE: begin
                issue    = 1'b1;
                to_cnt_d = TO_LOAD;
                state_d  = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (SDRAM_STATUS) begin
                    state_d = S_WAIT_DONE;
                end else if (to_cnt_q == '0) begin
                    to_fire = 1'b1;
                    state_d = S_ISSUE;
                end else begin
                    to_cnt_d = to_cnt_q - 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!SDRAM_STATUS) begin
                    if (cur_is_read) begin
                        next_r_d = 1'b1;
                        clr_rd   = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        next_w_d = 1'b1;
                        if ((idx_q + 4'd1) < cur_len) begin
                            idx_d   = idx_q + 4'd1;
                            state_d = S_ISSUE;
                        end else begin
                            for (int c = 0; c < NUM_CH; c++) begin
                                if (slot_q == SW'(c)) begin
                                    clr_ch[c] = 1'b1;
                                end
                            end
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Registered command outputs; data/address hold until the next issue.
    always_ff @(posedge CLK_48MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            CMD_OUT     <= 2'b00;
            DATA_OUT    <= '0;
            BA_OUT      <= '0;
            ROW_OUT     <= '0;
            COL_OUT     <= '0;
            NEXT_WRITE  <= 1'b0;
            NEXT_READ   <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
        end else begin
            CMD_OUT    <= 2'b00;
            NEXT_WRITE <= next_w_d;
            NEXT_READ  <= next_r_d;
            if (to_fire) begin
                TIMEOUT_ERR <= 1'b1;
            end
            if (issue) begin
                if (cur_is_read) begin
                    CMD_OUT <= 2'b01;
                    BA_OUT  <= BA_READ;
                    ROW_OUT <= ROW_READ;
                    COL_OUT <= COL_READ;
                end else begin
                    CMD_OUT  <= 2'b10;
                    DATA_OUT <= cur_word;
                    BA_OUT   <= BA_WRITE;
                    ROW_OUT  <= ROW_WRITE;
                    COL_OUT  <= COL_WRITE;
                end
            end
        end
    end

endmodule

// File: tb/tb_sdram_sched.sv
// Bench for sdram_sched: two instances (read priority on / off) share stimulus,
// each with its own SDRAM interface model and command log.
module tb_sdram_sched;
    localparam int NCH     = 2;
    localparam int MW      = 5;
    localparam int TO      = 15;
    localparam int ACK_DLY = 2;
    localparam int BUSY    = 4;
    localparam logic [1:0]  WBA  = 2'd1;
    localparam logic [12:0] WROW = 13'h0AA;
    localparam logic [8:0]  WCOL = 9'h055;
    localparam logic [1:0]  RBA  = 2'd2;
    localparam logic [12:0] RROW = 13'h123;
    localparam logic [8:0]  RCOL = 9'h0F0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NCH-1:0] ch_valid = '0;
    logic [NCH*MW*16-1:0] ch_data = '0;
    logic [NCH*4-1:0] ch_len = '0;
    logic read_cmd = 1'b0;
    logic st0 = 1'b0;
    logic st1 = 1'b0;

    logic [1:0] cmd0, cmd1, ba0, ba1;
    logic [15:0] data0, data1;
    logic [12:0] row0, row1;
    logic [8:0] col0, col1;
    logic nw0, nw1, nr0, nr1, to0, to1;
    logic [NCH:0] drop0, drop1;

    int checks = 0;
    int failures = 0;
    bit force_busy = 1'b0;
    bit no_ack = 1'b0;
    int ph0 = 0;
    int ph1 = 0;
    logic [1:0] lc0[$];
    logic [1:0] lc1[$];
    logic [15:0] ld0[$];
    logic [15:0] ld1[$];
    int nw0c = 0, nr0c = 0, nw1c = 0, nr1c = 0;

    typedef struct {
        int          ch;
        int          len;
        int          exp_n;
        logic [2:0]  exp_drop;
        logic [15:0] base;
    } vec_t;
    vec_t vecs[6];

    always #10 clk = ~clk;

    sdram_sched #(.NUM_CH(NCH), .MAX_WORDS(MW), .READ_PRIORITY(1), .ACK_TIMEOUT(TO)) u0 (
        .CLK_48MHZ(clk), .RESET_N(rst_n), .CH_VALID(ch_valid), .CH_DATA(ch_data),
        .CH_LEN(ch_len), .READ_CMD(read_cmd), .SDRAM_STATUS(st0),
        .BA_WRITE(WBA), .ROW_WRITE(WROW), .COL_WRITE(WCOL),
        .BA_READ(RBA), .ROW_READ(RROW), .COL_READ(RCOL),
        .CMD_OUT(cmd0), .DATA_OUT(data0), .BA_OUT(ba0), .ROW_OUT(row0), .COL_OUT(col0),
        .NEXT_WRITE(nw0), .NEXT_READ(nr0), .DROP(drop0), .TIMEOUT_ERR(to0));

    sdram_sched #(.NUM_CH(NCH), .MAX_WORDS(MW), .READ_PRIORITY(0), .ACK_TIMEOUT(TO)) u1 (
        .CLK_48MHZ(clk), .RESET_N(rst_n), .CH_VALID(ch_valid), .CH_DATA(ch_data),
        .CH_LEN(ch_len), .READ_CMD(read_cmd), .SDRAM_STATUS(st1),
        .BA_WRITE(WBA), .ROW_WRITE(WROW), .COL_WRITE(WCOL),
        .BA_READ(RBA), .ROW_READ(RROW), .COL_READ(RCOL),
        .CMD_OUT(cmd1), .DATA_OUT(data1), .BA_OUT(ba1), .ROW_OUT(row1), .COL_OUT(col1),
        .NEXT_WRITE(nw1), .NEXT_READ(nr1), .DROP(drop1), .TIMEOUT_ERR(to1));

    // SDRAM interface models: rise ACK_DLY cycles after a command, busy for BUSY cycles.
    always @(negedge clk) begin
        if (!rst_n) begin
            ph0 = 0; st0 = 1'b0; ph1 = 0; st1 = 1'b0;
        end else begin
            if (force_busy) st0 = 1'b1;
            else if (cmd0 != 2'b00 && !no_ack) begin ph0 = 1; st0 = 1'b0; end
            else if (ph0 > 0) begin
                ph0++;
                st0 = (ph0 > ACK_DLY && ph0 <= ACK_DLY + BUSY);
                if (ph0 > ACK_DLY + BUSY) ph0 = 0;
            end else st0 = 1'b0;
            if (force_busy) st1 = 1'b1;
            else if (cmd1 != 2'b00 && !no_ack) begin ph1 = 1; st1 = 1'b0; end
            else if (ph1 > 0) begin
                ph1++;
                st1 = (ph1 > ACK_DLY && ph1 <= ACK_DLY + BUSY);
                if (ph1 > ACK_DLY + BUSY) ph1 = 0;
            end else st1 = 1'b0;
        end
    end

    // Command / pulse logs.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd0 != 2'b00) begin lc0.push_back(cmd0); ld0.push_back(data0); end
            if (cmd1 != 2'b00) begin lc1.push_back(cmd1); ld1.push_back(data1); end
            if (nw0) nw0c++;
            if (nr0) nr0c++;
            if (nw1) nw1c++;
            if (nr1) nr1c++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_ch(input logic [NCH-1:0] m);
        @(negedge clk);
        ch_valid = m;
        @(negedge clk);
        ch_valid = '0;
    endtask

    task automatic load(input int c, input int len, input logic [15:0] base);
        for (int i = 0; i < MW; i++) ch_data[(c*MW+i)*16 +: 16] = base + 16'(i);
        ch_len[c*4 +: 4] = 4'(len);
    endtask

    task automatic clear_logs();
        lc0.delete(); ld0.delete(); lc1.delete(); ld1.delete();
        nw0c = 0; nr0c = 0; nw1c = 0; nr1c = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        cyc(2);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_writes0(input string nm, input int n, input logic [15:0] base);
        chk({nm, "_count"}, 32'(lc0.size()), 32'(n));
        chk({nm, "_next_write"}, 32'(nw0c), 32'(n));
        for (int i = 0; i < n && i < lc0.size(); i++) begin
            chk({nm, "_cmd"}, 32'(lc0[i]), 32'd2);
            chk({nm, "_data"}, 32'(ld0[i]), 32'(base + 16'(i)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        bool_blk: begin end
        vecs[0] = '{1, 2,  2, 3'b000, 16'h3001};
        vecs[1] = '{0, 5,  5, 3'b000, 16'h3101};
        vecs[2] = '{1, 9,  5, 3'b000, 16'h3201};
        vecs[3] = '{0, 1,  1, 3'b000, 16'h3301};
        vecs[4] = '{0, 0,  0, 3'b001, 16'h3401};
        vecs[5] = '{1, 15, 5, 3'b001, 16'h3501};

        // reset values
        cyc(3);
        chk("rst_cmd", 32'(cmd0), 32'd0);
        chk("rst_data", 32'(data0), 32'd0);
        chk("rst_addr", {8'd0, ba0, row0, col0}, 32'd0);
        chk("rst_next", {30'd0, nw0, nr0}, 32'd0);
        chk("rst_drop", 32'(drop0), 32'd0);
        chk("rst_timeout", 32'(to0), 32'd0);
        chk("rst_u1", {2'd0, cmd1, data1, ba1, to1, drop1, nw1, nr1, 2'd0}, 32'd0);
        chk("rst_u1_addr", {10'd0, row1, col1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // single write, latency, data sequence and hold
        cyc(2);
        load(0, 3, 16'h0001);
        clear_logs();
        pulse_ch(2'b01);
        cyc(1);
        chk("lat_w_early", 32'(cmd0), 32'd0);
        cyc(1);
        chk("lat_w_cmd", 32'(cmd0), 32'd2);
        chk("lat_w_data", 32'(data0), 32'h0001);
        chk("lat_w_addr", {8'd0, ba0, row0, col0}, {8'd0, WBA, WROW, WCOL});
        cyc(35);
        chk_writes0("single", 3, 16'h0001);
        chk("single_hold", 32'(data0), 32'h0003);
        chk("single_drop", 32'(drop0), 32'd0);

        // read latency and address
        clear_logs();
        @(negedge clk);
        read_cmd = 1'b1;
        cyc(3);
        chk("lat_r_early", 32'(cmd0), 32'd0);
        cyc(1);
        chk("lat_r_cmd", 32'(cmd0), 32'd1);
        chk("lat_r_addr", {8'd0, ba0, row0, col0}, {8'd0, RBA, RROW, RCOL});
        cyc(15);
        chk("read_next_read", 32'(nr0c), 32'd1);
        chk("read_count", 32'(lc0.size()), 32'd1);
        @(negedge clk);
        read_cmd = 1'b0;
        cyc(2);

        // table: lengths, clamping, zero length
        for (int v = 0; v < 6; v++) begin
            load(vecs[v].ch, vecs[v].len, vecs[v].base);
            clear_logs();
            pulse_ch(NCH'(1) << vecs[v].ch);
            cyc(55);
            chk_writes0($sformatf("vec%0d", v), vecs[v].exp_n, vecs[v].base);
            chk($sformatf("vec%0d_drop", v), 32'(drop0), 32'(vecs[v].exp_drop));
        end

        // ACK timeout and re-issue
        no_ack = 1'b1;
        load(0, 1, 16'hBEEF);
        clear_logs();
        pulse_ch(2'b01);
        seen = 0;
        for (int k = 0; k < 10 && seen == 0; k++) begin
            cyc(1);
            if (cmd0 != 2'b00) seen = 1;
        end
        chk("to_first_issue", 32'(seen), 32'd1);
        chk("to_err_before", 32'(to0), 32'd0);
        seen = 0;
        for (int j = 1; j <= TO; j++) begin
            cyc(1);
            if (cmd0 != 2'b00) seen++;
            if (j == TO) no_ack = 1'b0;
        end
        chk("to_no_early_reissue", 32'(seen), 32'd0);
        cyc(1);
        chk("to_reissue_cmd", 32'(cmd0), 32'd2);
        chk("to_reissue_data", 32'(data0), 32'hBEEF);
        chk("to_err", 32'(to0), 32'd1);
        cyc(20);
        chk("to_issue_count", 32'(lc0.size()), 32'd2);
        chk("to_next_write", 32'(nw0c), 32'd1);

        // reset during WAIT_DONE of word 2, then clean restart
        load(0, 3, 16'h0A01);
        clear_logs();
        pulse_ch(2'b01);
        seen = 0;
        for (int k = 0; k < 40 && seen < 2; k++) begin
            cyc(1);
            if (cmd0 != 2'b00) seen++;
        end
        chk("rmid_second_issue", 32'(seen), 32'd2);
        cyc(4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rmid_data", 32'(data0), 32'd0);
        chk("rmid_cmd_addr", {6'd0, cmd0, ba0, row0, col0}, 32'd0);
        chk("rmid_timeout", 32'(to0), 32'd0);
        chk("rmid_drop_next", {27'd0, drop0, nw0}, 32'd0);
        cyc(2);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(2);
        load(0, 2, 16'h0B01);
        clear_logs();
        pulse_ch(2'b01);
        cyc(30);
        chk_writes0("restart", 2, 16'h0B01);

        // repeated packet on the channel in service is dropped
        load(1, 3, 16'h0C01);
        clear_logs();
        pulse_ch(2'b10);
        cyc(10);
        load(1, 3, 16'h0D01);
        pulse_ch(2'b10);
        cyc(40);
        chk_writes0("busy_drop", 3, 16'h0C01);
        chk("busy_drop_flags", 32'(drop0), 32'b010);

        // simultaneous requests: order with and without read priority
        do_reset();
        load(0, 5, 16'h1001);
        load(1, 5, 16'h2001);
        clear_logs();
        @(negedge clk);
        force_busy = 1'b1;
        @(negedge clk);
        ch_valid = 2'b11;
        read_cmd = 1'b1;
        @(negedge clk);
        ch_valid = 2'b00;
        cyc(4);
        @(negedge clk);
        force_busy = 1'b0;
        cyc(120);
        read_cmd = 1'b0;
        chk("prio_count", 32'(lc0.size()), 32'd11);
        chk("rr_count", 32'(lc1.size()), 32'd11);
        for (int i = 0; i < 11; i++) begin
            if (i < lc0.size()) begin
                if (i == 0) chk("prio_cmd_read", 32'(lc0[i]), 32'd1);
                else begin
                    chk("prio_cmd", 32'(lc0[i]), 32'd2);
                    chk("prio_data", 32'(ld0[i]), (i <= 5) ? 32'h1000 + 32'(i) : 32'h2000 + 32'(i - 5));
                end
            end
            if (i < lc1.size()) begin
                if (i == 10) chk("rr_cmd_read", 32'(lc1[i]), 32'd1);
                else begin
                    chk("rr_cmd", 32'(lc1[i]), 32'd2);
                    chk("rr_data", 32'(ld1[i]), (i < 5) ? 32'h1001 + 32'(i) : 32'h2001 + 32'(i - 5));
                end
            end
        end
        chk("prio_next_read", 32'(nr0c), 32'd1);
        chk("rr_next_write", 32'(nw1c), 32'd10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
